// File: rtl/mips_cpu_data_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_cpu_bus_pkg
// Purpose  : Shared types and constants for the CPU data-port bridge.
//            Bridge FSM states, request kinds, bus byte-enable constant.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mips_cpu_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } bridge_state_t;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } req_kind_t;

    localparam logic [3:0] BYTEEN_ALL = 4'hF;

endpackage : mips_cpu_bus_pkg
`default_nettype wire

// File: rtl/mips_cpu_data_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : mips_cpu_data_bridge_if
// Purpose  : Avalon-MM-style wait-state memory bus between the bridge
//            (master) and the memory (slave).
// Signals  : avm_address, avm_read, avm_write, avm_writedata,
//            avm_byteenable (master -> slave);
//            avm_readdata, avm_waitrequest (slave -> master).
// Revision : 1.0 - initial release
// ============================================================================
interface mips_cpu_data_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   avm_address;
    logic                avm_read;
    logic                avm_write;
    logic [DATA_W-1:0]   avm_writedata;
    logic [DATA_W/8-1:0] avm_byteenable;
    logic [DATA_W-1:0]   avm_readdata;
    logic                avm_waitrequest;

    modport master (
        output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
        input  avm_readdata, avm_waitrequest
    );

    modport slave (
        input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
        output avm_readdata, avm_waitrequest
    );
endinterface : mips_cpu_data_bridge_if
`default_nettype wire

// File: rtl/mips_cpu_rdbuf.sv
`default_nettype none
// ============================================================================
// Module   : mips_cpu_rdbuf
// Purpose  : One-entry read buffer {valid, address, data} for the CPU data
//            bridge. Used only when MIPS_BRIDGE_RDBUF_EN is defined.
// Ports    : clk, reset (async, active-low)
//            fill_en/fill_addr/fill_data : load entry on read completion
//            upd_en/upd_addr/upd_data    : write completion, updates data
//                                          when the address is buffered
//            lookup_addr -> hit, hit_data : combinational lookup
// Revision : 1.0 - initial release
// ============================================================================
module mips_cpu_rdbuf #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fill_en,
    input  logic [ADDR_W-1:0] fill_addr,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              upd_en,
    input  logic [ADDR_W-1:0] upd_addr,
    input  logic [DATA_W-1:0] upd_data,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              hit,
    output logic [DATA_W-1:0] hit_data
);
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] data_q,  data_d;

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (fill_en) begin
            valid_d = 1'b1;
            addr_d  = fill_addr;
            data_d  = fill_data;
        end else if (upd_en && valid_q && (upd_addr == addr_q)) begin
            // Keep the entry coherent with writes that go around it.
            data_d = upd_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign hit      = valid_q && (addr_q == lookup_addr);
    assign hit_data = data_q;

endmodule : mips_cpu_rdbuf
`default_nettype wire

// File: rtl/mips_cpu_data_bridge.sv
`default_nettype none
// ============================================================================
// Module   : mips_cpu_data_bridge
// Purpose  : Bridges the CPU Harvard data port to a wait-state memory bus
//            with waitrequest semantics, stalling the CPU while a transfer
//            is outstanding. Drive the CPU clk_enable with !cpu_stall.
// Ports    : clk, reset (async, active-low)
//            cpu_address/cpu_read/cpu_write/cpu_writedata : CPU request
//            cpu_readdata : read result, held until the next read completes
//            cpu_stall    : combinational, 1 = CPU must hold
//            avm          : memory bus (mips_cpu_data_bridge_if.master)
// Options  : MIPS_BRIDGE_RDBUF_EN - adds a one-entry read buffer that
//            answers repeated reads without a bus access.
// Revision : 1.0 - initial release
// ============================================================================
module mips_cpu_data_bridge
    import mips_cpu_bus_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ADDR_W-1:0]      cpu_address,
    input  logic                   cpu_read,
    input  logic                   cpu_write,
    input  logic [DATA_W-1:0]      cpu_writedata,
    output logic [DATA_W-1:0]      cpu_readdata,
    output logic                   cpu_stall,
    mips_cpu_data_bridge_if.master avm
);
    bridge_state_t     state_q, state_d;
    logic              tag_valid_q, tag_valid_d;
    req_kind_t         tag_kind_q, tag_kind_d;
    logic [ADDR_W-1:0] tag_addr_q, tag_addr_d;
    req_kind_t         kind_q, kind_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;

    req_kind_t         w_kind;
    logic              w_req;
    logic              w_new_req;
    logic              w_bus_done;
    logic              w_buf_hit;
    logic [DATA_W-1:0] w_buf_data;
    logic              w_buf_take;

    // Write wins when both strobes are high.
    assign w_kind = cpu_write ? WRITE : READ;
    assign w_req  = cpu_read | cpu_write;

    // A request identical to the last completed transfer is the CPU still
    // holding its strobe through EXEC; it must not start another transfer.
    assign w_new_req = w_req && !(tag_valid_q && (tag_kind_q == w_kind)
                                  && (tag_addr_q == cpu_address));

    assign w_bus_done = (state_q == BUS) && !avm.avm_waitrequest;

`ifdef MIPS_BRIDGE_RDBUF_EN
    mips_cpu_rdbuf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_rdbuf (
        .clk         (clk),
        .reset       (reset),
        .fill_en     (w_bus_done && (kind_q == READ)),
        .fill_addr   (addr_q),
        .fill_data   (avm.avm_readdata),
        .upd_en      (w_bus_done && (kind_q == WRITE)),
        .upd_addr    (addr_q),
        .upd_data    (wdata_q),
        .lookup_addr (cpu_address),
        .hit         (w_buf_hit),
        .hit_data    (w_buf_data)
    );
`else
    assign w_buf_hit  = 1'b0;
    assign w_buf_data = '0;
`endif

    // A buffered read is answered in the IDLE cycle it appears.
    assign w_buf_take = (state_q == IDLE) && w_new_req && (w_kind == READ)
                        && w_buf_hit;

    always_comb begin
        state_d     = state_q;
        tag_valid_d = tag_valid_q;
        tag_kind_d  = tag_kind_q;
        tag_addr_d  = tag_addr_q;
        kind_d      = kind_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        rd_d        = rd_q;
        wr_d        = wr_q;

        if (!w_req) begin
            tag_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (w_buf_take) begin
                    // Copy into rdata_q so the value persists after the hit.
                    tag_valid_d = 1'b1;
                    tag_kind_d  = READ;
                    tag_addr_d  = cpu_address;
                    rdata_d     = w_buf_data;
                end else if (w_new_req) begin
                    kind_d  = w_kind;
                    addr_d  = cpu_address;
                    wdata_d = cpu_writedata;
                    rd_d    = (w_kind == READ);
                    wr_d    = (w_kind == WRITE);
                    state_d = BUS;
                end
            end
            BUS: begin
                if (!avm.avm_waitrequest) begin
                    if (kind_q == READ) begin
                        rdata_d = avm.avm_readdata;
                    end
                    tag_valid_d = 1'b1;
                    tag_kind_d  = kind_q;
                    tag_addr_d  = addr_q;
                    rd_d        = 1'b0;
                    wr_d        = 1'b0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            tag_valid_q <= 1'b0;
            tag_kind_q  <= READ;
            tag_addr_q  <= '0;
            kind_q      <= READ;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            tag_valid_q <= tag_valid_d;
            tag_kind_q  <= tag_kind_d;
            tag_addr_q  <= tag_addr_d;
            kind_q      <= kind_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
        end
    end

    assign cpu_stall    = ((state_q == IDLE) && w_new_req && !w_buf_take)
                          || (state_q == BUS);
    assign cpu_readdata = w_buf_take ? w_buf_data : rdata_q;

    assign avm.avm_address    = addr_q;
    assign avm.avm_writedata  = wdata_q;
    assign avm.avm_read       = rd_q;
    assign avm.avm_write      = wr_q;
    assign avm.avm_byteenable = BYTEEN_ALL;

endmodule : mips_cpu_data_bridge
`default_nettype wire

// File: tb/tb_mips_cpu_data_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_cpu_data_bridge
// Purpose  : Self-checking bench for mips_cpu_data_bridge. A transaction-level
//            model predicts stall, bus command and read data per cycle; a
//            negedge process compares the DUT against it. Directed literal
//            checks pin the model; then randomized traffic follows.
// Options  : MIPS_BRIDGE_RDBUF_EN - also models and checks the read buffer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_cpu_data_bridge;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] cpu_address = '0;
    logic        cpu_read = 1'b0;
    logic        cpu_write = 1'b0;
    logic [31:0] cpu_writedata = '0;
    logic [31:0] cpu_readdata;
    logic        cpu_stall;

    mips_cpu_data_bridge_if bus_if ();

    mips_cpu_data_bridge dut (
        .clk           (clk),
        .reset         (reset),
        .cpu_address   (cpu_address),
        .cpu_read      (cpu_read),
        .cpu_write     (cpu_write),
        .cpu_writedata (cpu_writedata),
        .cpu_readdata  (cpu_readdata),
        .cpu_stall     (cpu_stall),
        .avm           (bus_if.master)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Expected per-cycle outputs and transaction-level model state.
    bit          chk_en = 1'b0;
    bit          e_stall = 1'b0, e_rd = 1'b0, e_wr = 1'b0;
    logic [31:0] e_addr = '0, e_wd = '0;
    logic [31:0] m_rdata = '0;
    bit          m_tag_v = 1'b0, m_tag_wr = 1'b0;
    logic [31:0] m_tag_a = '0;
    bit          m_buf_v = 1'b0;
    logic [31:0] m_buf_a = '0, m_buf_d = '0;
    logic [31:0] mem [logic [31:0]];

    int n_rd = 0, n_wr = 0, n_st = 0;
    int s_rd, s_wr, s_st;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {~a[15:0], a[15:0]};
    endfunction

    // Compare process: every cycle, away from the rising edge.
    always @(negedge clk) begin
        if (bus_if.avm_read)  n_rd++;
        if (bus_if.avm_write) n_wr++;
        if (cpu_stall)        n_st++;
        if (chk_en) begin
            chk("cpu_stall", {31'b0, cpu_stall}, {31'b0, e_stall});
            chk("avm_read", {31'b0, bus_if.avm_read}, {31'b0, e_rd});
            chk("avm_write", {31'b0, bus_if.avm_write}, {31'b0, e_wr});
            chk("avm_byteenable", {28'b0, bus_if.avm_byteenable}, 32'hF);
            chk("cpu_readdata", cpu_readdata, m_rdata);
            if (e_rd || e_wr) chk("avm_address", bus_if.avm_address, e_addr);
            if (e_wr)         chk("avm_writedata", bus_if.avm_writedata, e_wd);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            cpu_read    = 1'b0;
            cpu_write   = 1'b0;
            cpu_address = $urandom;
            e_stall = 1'b0; e_rd = 1'b0; e_wr = 1'b0;
            m_tag_v = 1'b0;
        end
    endtask

    // One CPU request: presented for cycle 0, held until released by the
    // bridge, then held for 'hold' further cycles.
    task automatic xfer(input bit wr, input bit both, input logic [31:0] a,
                        input logic [31:0] wd, input int waits, input int hold);
        logic [31:0] rd;
        rd = mem_rd(a);
        step();
        cpu_address   = a;
        cpu_write     = wr;
        cpu_read      = wr ? both : 1'b1;
        cpu_writedata = wd;
        bus_if.avm_readdata    = wr ? $urandom : rd;
        bus_if.avm_waitrequest = (waits > 0);
        e_rd = 1'b0; e_wr = 1'b0;
        if (m_tag_v && (m_tag_wr == wr) && (m_tag_a == a)) begin
            e_stall = 1'b0;
        end
`ifdef MIPS_BRIDGE_RDBUF_EN
        else if (!wr && m_buf_v && (m_buf_a == a)) begin
            e_stall = 1'b0;
            m_rdata = m_buf_d;
            m_tag_v = 1'b1; m_tag_wr = 1'b0; m_tag_a = a;
        end
`endif
        else begin
            e_stall = 1'b1;
            for (int c = 1; c <= waits + 1; c++) begin
                step();
                bus_if.avm_waitrequest = (c <= waits);
                e_stall = 1'b1; e_rd = !wr; e_wr = wr; e_addr = a; e_wd = wd;
            end
            step();
            bus_if.avm_waitrequest = 1'($urandom_range(0, 1));
            e_stall = 1'b0; e_rd = 1'b0; e_wr = 1'b0;
            m_tag_v = 1'b1; m_tag_wr = wr; m_tag_a = a;
            if (wr) begin
                mem[a] = wd;
                if (m_buf_v && (m_buf_a == a)) m_buf_d = wd;
            end else begin
                m_rdata = rd;
                m_buf_v = 1'b1; m_buf_a = a; m_buf_d = rd;
            end
        end
        for (int h = 0; h < hold; h++) begin
            step();
            e_stall = 1'b0; e_rd = 1'b0; e_wr = 1'b0;
        end
    endtask

    task automatic snap();
        s_rd = n_rd; s_wr = n_wr; s_st = n_st;
    endtask

    initial begin
        bus_if.avm_readdata    = '0;
        bus_if.avm_waitrequest = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", {31'b0, cpu_stall}, 32'd0);
        chk("rst_avm_read", {31'b0, bus_if.avm_read}, 32'd0);
        chk("rst_avm_write", {31'b0, bus_if.avm_write}, 32'd0);
        chk("rst_avm_address", bus_if.avm_address, 32'd0);
        chk("rst_avm_writedata", bus_if.avm_writedata, 32'd0);
        chk("rst_byteenable", {28'b0, bus_if.avm_byteenable}, 32'hF);
        chk("rst_readdata", cpu_readdata, 32'd0);
        reset  = 1'b1;
        chk_en = 1'b1;

        // Zero-wait read: 2 stall cycles, one read pulse.
        mem[32'h1000] = 32'hDEADBEEF;
        snap();
        xfer(1'b0, 1'b0, 32'h1000, 32'h0, 0, 0);
        chk("zw_readdata", cpu_readdata, 32'hDEADBEEF);
        idle(1);
        chk("zw_read_cycles", n_rd - s_rd, 32'd1);
        chk("zw_stall_cycles", n_st - s_st, 32'd2);

        // Write with 3 waitrequest cycles: command held 4 cycles, stall 5.
        snap();
        xfer(1'b1, 1'b0, 32'h2000, 32'h12345678, 3, 0);
        idle(1);
        chk("wr_write_cycles", n_wr - s_wr, 32'd4);
        chk("wr_stall_cycles", n_st - s_st, 32'd5);

        // Read held through EXEC: no second transfer.
        mem[32'h4000] = 32'h600DF00D;
        snap();
        xfer(1'b0, 1'b0, 32'h4000, 32'h0, 1, 3);
        chk("hold_readdata", cpu_readdata, 32'h600DF00D);
        idle(1);
        chk("hold_read_cycles", n_rd - s_rd, 32'd2);

        // SB pattern: read then write to one address, no idle gap.
        snap();
        xfer(1'b0, 1'b0, 32'h3000, 32'h0, 0, 0);
        xfer(1'b1, 1'b0, 32'h3000, 32'hCAFE0001, 0, 0);
        idle(1);
        chk("sb_read_cycles", n_rd - s_rd, 32'd1);
        chk("sb_write_cycles", n_wr - s_wr, 32'd1);

        // Reset during BUS with waitrequest held.
        step();
        cpu_read = 1'b1; cpu_write = 1'b0; cpu_address = 32'h5000;
        bus_if.avm_waitrequest = 1'b1;
        e_stall = 1'b1; e_rd = 1'b0; e_wr = 1'b0;
        step();
        e_stall = 1'b1; e_rd = 1'b1; e_addr = 32'h5000;
        @(negedge clk);
        #2;
        chk_en = 1'b0;
        reset  = 1'b0;
        #1;
        chk("arst_avm_read", {31'b0, bus_if.avm_read}, 32'd0);
        chk("arst_readdata", cpu_readdata, 32'd0);
        chk("arst_stall_req", {31'b0, cpu_stall}, 32'd1);
        cpu_read = 1'b0;
        #1;
        chk("arst_stall_idle", {31'b0, cpu_stall}, 32'd0);
        step();
        reset = 1'b1;
        m_rdata = '0; m_tag_v = 1'b0; m_buf_v = 1'b0;
        e_stall = 1'b0; e_rd = 1'b0; e_wr = 1'b0;
        bus_if.avm_waitrequest = 1'b0;
        chk_en = 1'b1;

`ifdef MIPS_BRIDGE_RDBUF_EN
        // Buffered read after a write to the same address.
        mem[32'h1000] = 32'hA5A5A5A5;
        xfer(1'b0, 1'b0, 32'h1000, 32'h0, 0, 0);
        xfer(1'b1, 1'b0, 32'h1000, 32'h0F0F0F0F, 1, 0);
        idle(1);
        snap();
        xfer(1'b0, 1'b0, 32'h1000, 32'h0, 0, 0);
        chk("buf_readdata", cpu_readdata, 32'h0F0F0F0F);
        chk("buf_stall", {31'b0, cpu_stall}, 32'd0);
        idle(1);
        chk("buf_read_cycles", n_rd - s_rd, 32'd0);
`endif

        // Randomized traffic over a small address set to exercise tag reuse.
        for (int t = 0; t < 300; t++) begin
            bit          wr;
            logic [31:0] a;
            int          gap;
            wr  = ($urandom_range(0, 2) == 0);
            a   = 32'h1000 + (32'($urandom_range(0, 3)) << 2);
            gap = $urandom_range(0, 2);
            if (gap > 0) idle(gap);
            xfer(wr, 1'($urandom_range(0, 1)), a, $urandom,
                 $urandom_range(0, 3), $urandom_range(0, 2));
        end
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mips_cpu_data_bridge
`default_nettype wire
